// File: rtl/ascon_sio_pkg.sv
// Shared types and elaboration helpers for the ASCON share serial I/O block.
// Holds the FSM encoding, lane-width legality check and beat-count helper.
package ascon_sio_pkg;

   typedef enum logic [1:0] {StLoad, StLoaded, StBusy, StUnload} state_e;

   localparam int unsigned NonceLen = 128;

   function automatic bit w_legal(input int unsigned w, input int unsigned k,
                                  input int unsigned l, input int unsigned y);
      return (w == 1 || w == 2 || w == 4 || w == 8) && (k % w == 0) && (l % w == 0) &&
             (y % w == 0) && (NonceLen % w == 0);
   endfunction

   // Beats needed to fill (or drain) the longest of the given fields and the nonce.
   function automatic int unsigned beat_count(input int unsigned w, input int unsigned k,
                                              input int unsigned l, input int unsigned y);
      int unsigned m;
      m = NonceLen;
      if (k > m) m = k;
      if (l > m) m = l;
      if (y > m) m = y;
      return m / w;
   endfunction

endpackage

// File: rtl/ascon_sio_if.sv
// Serial load/unload stream bundle between the ASCON share I/O block and its host.
// Lane s of each input field occupies bits [s*W +: W].
interface ascon_sio_if #(
   parameter int unsigned S = 5,
   parameter int unsigned W = 1
);

   logic           in_valid;
   logic           in_ready;
   logic [S*W-1:0] key_in;
   logic [S*W-1:0] nonce_in;
   logic [S*W-1:0] ad_in;
   logic [S*W-1:0] pt_in;

   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_ct;
   logic [W-1:0]   out_tag;
   logic           out_ct_vld;
   logic           out_tag_vld;
   logic           out_last;
   logic           out_auth_ok;

   modport master (
      output in_valid, key_in, nonce_in, ad_in, pt_in, out_ready,
      input  in_ready, out_valid, out_ct, out_tag, out_ct_vld, out_tag_vld, out_last,
             out_auth_ok
   );

   modport slave (
      input  in_valid, key_in, nonce_in, ad_in, pt_in, out_ready,
      output in_ready, out_valid, out_ct, out_tag, out_ct_vld, out_tag_vld, out_last,
             out_auth_ok
   );

endinterface

// File: rtl/ascon_sio_shreg.sv
// N-bit left-shift register fed W bits per beat, MSB-first; it stops shifting once
// N/W beats have been taken so shorter fields keep their first N bits.
module ascon_sio_shreg #(
   parameter int unsigned N    = 32,
   parameter int unsigned W    = 1,
   parameter int unsigned CntW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   input  logic [CntW-1:0] cnt,
   input  logic [W-1:0]    lane,
   output logic [N-1:0]    q
);

   localparam int unsigned Beats = N / W;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (en && (cnt < CntW'(Beats))) begin
         q <= {q[N-W-1:0], lane};
      end
   end

endmodule

// File: rtl/ascon_sio.sv
// Serial share loader and result unloader wrapped around an ASCON core: fields arrive
// W bits per share per beat, results leave LSB-first indexed from captured registers.
module ascon_sio
   import ascon_sio_pkg::*;
#(
   parameter int unsigned K = 128,
   parameter int unsigned L = 32,
   parameter int unsigned Y = 32,
   parameter int unsigned S = 5,
   parameter int unsigned W = 1
) (
   input  logic             clk,
   input  logic             rst,
   ascon_sio_if.slave       bus,
   input  logic             start,
   input  logic             abort,
   output logic             loaded,
   output logic             core_start,
   output logic [S*K-1:0]   key_sh,
   output logic [S*128-1:0] nonce_sh,
   output logic [S*L-1:0]   ad_sh,
   output logic [S*Y-1:0]   pt_sh,
   input  logic             core_done,
   input  logic [Y-1:0]     core_ct,
   input  logic [127:0]     core_tag,
   input  logic             core_auth_ok
);

   localparam int unsigned M   = beat_count(W, K, L, Y);
   localparam int unsigned U   = beat_count(W, Y, Y, Y);
   localparam int unsigned LcW = $clog2(M + 1);
   localparam int unsigned UcW = $clog2(U + 1);

   if (!w_legal(W, K, L, Y)) begin : g_bad_w
      $error("ascon_sio: W must be 1, 2, 4 or 8 and divide every field length");
   end

   state_e         state_q, state_d;
   logic [LcW-1:0] lc_q, lc_d;
   logic [UcW-1:0] uc_q, uc_d;
   logic [Y-1:0]   ct_q, ct_d;
   logic [127:0]   tag_q, tag_d;
   logic           auth_q, auth_d;
   logic           field_clr;
   logic           in_beat;

   assign in_beat = (state_q == StLoad) && bus.in_valid && !abort;

   always_comb begin
      state_d    = state_q;
      lc_d       = lc_q;
      uc_d       = uc_q;
      ct_d       = ct_q;
      tag_d      = tag_q;
      auth_d     = auth_q;
      field_clr  = 1'b0;
      core_start = 1'b0;
      if (abort) begin
         state_d   = StLoad;
         lc_d      = '0;
         uc_d      = '0;
         ct_d      = '0;
         tag_d     = '0;
         auth_d    = 1'b0;
         field_clr = 1'b1;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (bus.in_valid) begin
                  lc_d = lc_q + 1'b1;
                  if (lc_q == LcW'(M - 1)) state_d = StLoaded;
               end
            end
            StLoaded: begin
               if (start) begin
                  core_start = !rst;
                  state_d    = StBusy;
               end
            end
            StBusy: begin
               if (core_done) begin
                  ct_d    = core_ct;
                  tag_d   = core_tag;
                  auth_d  = core_auth_ok;
                  uc_d    = '0;
                  state_d = StUnload;
               end
            end
            StUnload: begin
               if (bus.out_ready) begin
                  if (uc_q == UcW'(U - 1)) begin
                     state_d   = StLoad;
                     lc_d      = '0;
                     uc_d      = '0;
                     field_clr = 1'b1;
                  end else begin
                     uc_d = uc_q + 1'b1;
                  end
               end
            end
            default: state_d = StLoad;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StLoad;
         lc_q    <= '0;
         uc_q    <= '0;
         ct_q    <= '0;
         tag_q   <= '0;
         auth_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lc_q    <= lc_d;
         uc_q    <= uc_d;
         ct_q    <= ct_d;
         tag_q   <= tag_d;
         auth_q  <= auth_d;
      end
   end

   for (genvar s = 0; s < S; s++) begin : g_share
      ascon_sio_shreg #(.N(K), .W(W), .CntW(LcW)) u_key (
         .clk(clk), .rst(rst), .clr(field_clr), .en(in_beat), .cnt(lc_q),
         .lane(bus.key_in[s*W +: W]), .q(key_sh[s*K +: K])
      );
      ascon_sio_shreg #(.N(128), .W(W), .CntW(LcW)) u_nonce (
         .clk(clk), .rst(rst), .clr(field_clr), .en(in_beat), .cnt(lc_q),
         .lane(bus.nonce_in[s*W +: W]), .q(nonce_sh[s*128 +: 128])
      );
      ascon_sio_shreg #(.N(L), .W(W), .CntW(LcW)) u_ad (
         .clk(clk), .rst(rst), .clr(field_clr), .en(in_beat), .cnt(lc_q),
         .lane(bus.ad_in[s*W +: W]), .q(ad_sh[s*L +: L])
      );
      ascon_sio_shreg #(.N(Y), .W(W), .CntW(LcW)) u_pt (
         .clk(clk), .rst(rst), .clr(field_clr), .en(in_beat), .cnt(lc_q),
         .lane(bus.pt_in[s*W +: W]), .q(pt_sh[s*Y +: Y])
      );
   end

   logic         unload;
   logic [W-1:0] ct_lane, tag_lane;

   assign unload = (state_q == StUnload);

   always_comb begin
      ct_lane  = '0;
      tag_lane = '0;
      for (int unsigned i = 0; i < Y / W; i++) begin
         if (uc_q == UcW'(i)) ct_lane = ct_q[i*W +: W];
      end
      for (int unsigned i = 0; i < 128 / W; i++) begin
         if (uc_q == UcW'(i)) tag_lane = tag_q[i*W +: W];
      end
   end

   // A failed authentication must never leak candidate plaintext/tag bits.
   always_comb begin
      bus.in_ready    = (state_q == StLoad);
      loaded          = (state_q == StLoaded);
      bus.out_valid   = unload;
      bus.out_ct_vld  = unload && (uc_q < UcW'(Y / W));
      bus.out_tag_vld = unload && (uc_q < UcW'(128 / W));
      bus.out_last    = unload && (uc_q == UcW'(U - 1));
      bus.out_auth_ok = auth_q;
      bus.out_ct      = (bus.out_ct_vld && auth_q) ? ct_lane : '0;
      bus.out_tag     = (bus.out_tag_vld && auth_q) ? tag_lane : '0;
   end

endmodule

// File: tb/tb_ascon_sio.sv
// Directed bench for ascon_sio: a W=1 instance for bit-serial loading and a W=8
// instance for byte-wide load, unload, stall, auth failure, abort and reset.
module tb_ascon_sio;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic         start1, abort1, loaded1, core_start1, core_done1;
   logic [639:0] key_sh1, nonce_sh1;
   logic [159:0] ad_sh1, pt_sh1;

   logic         start8, abort8, loaded8, core_start8, core_done8;
   logic [639:0] key_sh8, nonce_sh8;
   logic [159:0] ad_sh8, pt_sh8;

   logic [31:0]  core_ct;
   logic [127:0] core_tag;
   logic         core_auth_ok;

   ascon_sio_if #(.S(5), .W(1)) b1 ();
   ascon_sio_if #(.S(5), .W(8)) b8 ();

   ascon_sio #(.K(128), .L(32), .Y(32), .S(5), .W(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(b1), .start(start1), .abort(abort1), .loaded(loaded1),
      .core_start(core_start1), .key_sh(key_sh1), .nonce_sh(nonce_sh1), .ad_sh(ad_sh1),
      .pt_sh(pt_sh1), .core_done(core_done1), .core_ct(core_ct), .core_tag(core_tag),
      .core_auth_ok(core_auth_ok)
   );

   ascon_sio #(.K(128), .L(32), .Y(32), .S(5), .W(8)) u_dut8 (
      .clk(clk), .rst(rst), .bus(b8), .start(start8), .abort(abort8), .loaded(loaded8),
      .core_start(core_start8), .key_sh(key_sh8), .nonce_sh(nonce_sh8), .ad_sh(ad_sh8),
      .pt_sh(pt_sh8), .core_done(core_done8), .core_ct(core_ct), .core_tag(core_tag),
      .core_auth_ok(core_auth_ok)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] key_model(input logic [7:0] base);
      logic [127:0] e;
      e = '0;
      for (int i = 0; i < 16; i++) e = {e[119:0], base + 8'(i)};
      return e;
   endfunction

   // 16 byte-beats: key lane0 = base+i, key lane1 = F0, pt lane0 = A0+i.
   task automatic load8(input logic [7:0] base);
      for (int i = 0; i < 16; i++) begin
         b8.in_valid = 1'b1;
         b8.key_in   = {24'h0, 8'hF0, base + 8'(i)};
         b8.pt_in    = {32'h0, 8'hA0 + 8'(i)};
         if (i == 15) begin
            #1;
            chk("w8_not_loaded_before_last_beat", loaded8, 0);
         end
         tick();
      end
      b8.in_valid = 1'b0;
      b8.key_in   = '0;
      b8.pt_in    = '0;
      chk("w8_loaded", loaded8, 1);
      chk("w8_in_ready_low", b8.in_ready, 0);
      chk("w8_key_sh", key_sh8, {384'h0, {16{8'hF0}}, key_model(base)});
      chk("w8_pt_sh", pt_sh8, {128'h0, 32'hA0A1A2A3});
      chk("w8_nonce_ad_zero", {nonce_sh8, ad_sh8}, 0);
   endtask

   logic [127:0] tag_m;
   logic [7:0]   ct_exp [4];

   initial begin
      rst = 1'b1;
      {start1, abort1, core_done1, start8, abort8, core_done8} = '0;
      {b1.in_valid, b1.key_in, b1.nonce_in, b1.ad_in, b1.pt_in, b1.out_ready} = '0;
      {b8.in_valid, b8.key_in, b8.nonce_in, b8.ad_in, b8.pt_in, b8.out_ready} = '0;
      core_ct      = '0;
      core_tag     = '0;
      core_auth_ok = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready", {b8.in_ready, b1.in_ready}, 2'b11);
      chk("rst_loaded", {loaded8, loaded1}, 0);
      chk("rst_core_start", {core_start8, core_start1}, 0);
      chk("rst_out_valid", {b8.out_valid, b1.out_valid}, 0);
      chk("rst_out_last", {b8.out_last, b1.out_last}, 0);
      chk("rst_out_vld", {b8.out_ct_vld, b8.out_tag_vld, b1.out_ct_vld, b1.out_tag_vld}, 0);
      chk("rst_out_data", {b8.out_ct, b8.out_tag, b1.out_ct, b1.out_tag}, 0);
      chk("rst_out_auth_ok", {b8.out_auth_ok, b1.out_auth_ok}, 0);
      chk("rst_fields", {key_sh8, pt_sh8, key_sh1, ad_sh1}, 0);

      // W=1: 128 bit-beats, stray start mid-load
      for (int i = 0; i < 128; i++) begin
         b1.in_valid = 1'b1;
         b1.key_in   = 5'b00001;
         b1.ad_in    = (i < 32) ? 5'b00001 : 5'b00000;
         b1.pt_in    = (i < 32) ? 5'b00000 : 5'b00001;
         start1      = (i == 50);
         if (i == 50) begin
            #1;
            chk("w1_start_ignored_in_load", core_start1, 0);
         end
         if (i == 127) begin
            #1;
            chk("w1_not_loaded_at_127", {loaded1, b1.in_ready}, 2'b01);
         end
         tick();
      end
      b1.in_valid = 1'b0;
      start1      = 1'b0;
      chk("w1_loaded", {loaded1, b1.in_ready}, 2'b10);
      chk("w1_key_sh", key_sh1, {512'h0, {128{1'b1}}});
      chk("w1_ad_sh", ad_sh1, {128'h0, 32'hFFFF_FFFF});
      chk("w1_pt_count_limited", pt_sh1, 0);
      chk("w1_nonce_zero", nonce_sh1, 0);
      chk("w1_no_core_start_yet", core_start1, 0);
      start1 = 1'b1;
      #1;
      chk("w1_core_start_pulse", core_start1, 1);
      tick();
      chk("w1_core_start_one_cycle", {core_start1, loaded1}, 0);
      start1 = 1'b0;
      abort1 = 1'b1;
      tick();
      abort1 = 1'b0;
      chk("w1_abort_busy", {b1.in_ready, loaded1}, 2'b10);
      chk("w1_abort_clears_key", key_sh1, 0);

      // W=8: load, core_done outside BUSY ignored, start, authenticated unload with stall
      load8(8'h00);
      chk("w8_key_literal", key_sh8[127:0], 128'h000102030405060708090A0B0C0D0E0F);
      core_done8 = 1'b1;
      tick();
      core_done8 = 1'b0;
      chk("w8_done_ignored_in_loaded", {loaded8, b8.out_valid}, 2'b10);
      start8 = 1'b1;
      #1;
      chk("w8_core_start", core_start8, 1);
      tick();
      start8 = 1'b0;
      chk("w8_core_start_drop", core_start8, 0);
      chk("w8_busy_no_out_valid", b8.out_valid, 0);
      core_ct      = 32'h1234_5678;
      core_tag     = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      core_auth_ok = 1'b1;
      core_done8   = 1'b1;
      tick();
      core_done8 = 1'b0;
      core_ct    = '0;
      core_tag   = '0;
      chk("w8_unload_auth_ok", b8.out_auth_ok, 1);
      tag_m  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      ct_exp = '{8'h78, 8'h56, 8'h34, 8'h12};
      b8.out_ready = 1'b1;
      for (int u = 0; u < 16; u++) begin
         chk("w8_out_valid", b8.out_valid, 1);
         chk("w8_out_ct", {b8.out_ct_vld, b8.out_ct}, (u < 4) ? {1'b1, ct_exp[u]} : 9'h000);
         chk("w8_out_tag", {b8.out_tag_vld, b8.out_tag}, {1'b1, tag_m[u*8 +: 8]});
         chk("w8_out_last", b8.out_last, (u == 15));
         if (u == 5) begin
            b8.out_ready = 1'b0;
            repeat (3) begin
               tick();
               chk("w8_stall_hold", {b8.out_valid, b8.out_tag, b8.out_ct_vld, b8.out_ct},
                   {1'b1, 8'hAA, 1'b0, 8'h00});
            end
            b8.out_ready = 1'b1;
         end
         tick();
      end
      b8.out_ready = 1'b0;
      chk("w8_back_to_load", {b8.in_ready, b8.out_valid, b8.out_last, loaded8}, 4'b1000);
      chk("w8_fields_cleared", {key_sh8, pt_sh8}, 0);

      // W=8: failed authentication, then abort at uc=7
      load8(8'h20);
      start8 = 1'b1;
      tick();
      start8       = 1'b0;
      core_ct      = 32'hDEAD_BEEF;
      core_tag     = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
      core_auth_ok = 1'b0;
      core_done8   = 1'b1;
      tick();
      core_done8   = 1'b0;
      b8.out_ready = 1'b1;
      for (int u = 0; u < 7; u++) begin
         chk("w8_fail_zero_data", {b8.out_ct, b8.out_tag}, 0);
         chk("w8_fail_flags", {b8.out_valid, b8.out_tag_vld, b8.out_auth_ok}, 3'b110);
         tick();
      end
      b8.out_ready = 1'b0;
      chk("w8_fail_uc7_vld", {b8.out_valid, b8.out_ct_vld, b8.out_tag_vld}, 3'b101);
      abort8 = 1'b1;
      tick();
      abort8 = 1'b0;
      chk("w8_abort_state", {b8.in_ready, b8.out_valid, b8.out_tag_vld, loaded8}, 4'b1000);
      chk("w8_abort_key_zero", key_sh8, 0);
      chk("w8_abort_auth_cleared", b8.out_auth_ok, 0);

      // W=8: reset mid-load discards partial beats
      for (int i = 0; i < 5; i++) begin
         b8.in_valid = 1'b1;
         b8.key_in   = {32'h0, 8'h55};
         tick();
      end
      b8.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("w8_rst_midload", {b8.in_ready, loaded8}, 2'b10);
      chk("w8_rst_midload_key", key_sh8, 0);
      load8(8'h30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ascon_sio.md
ASCON_SIO -- requirements
Module: ascon_sio

Interface
REQ-001 Parameter K, default 128, key length in bits.
REQ-002 Parameter L, default 32, associated-data length in bits.
REQ-003 Parameter Y, default 32, plaintext/ciphertext length in bits.
REQ-004 Parameter S, default 5, share/channel count per field.
REQ-005 Parameter W, default 1, lane width in bits per beat; legal W is 1, 2, 4 or 8 and divides K, L, Y and 128.
REQ-006 Ports: clk in 1, clock; rst in 1, reset, synchronous, active-high; clk rising edge only.
REQ-007 Input-side ports: in_valid in 1; in_ready out 1; key_in in S*W; nonce_in in S*W; ad_in in S*W; pt_in in S*W (lane s = bits [s*W +: W]).
REQ-008 Control ports: start in 1, op request; abort in 1, sync flush; loaded out 1, all fields full.
REQ-009 Core-side outputs: core_start out 1; key_sh out S*K; nonce_sh out S*128; ad_sh out S*L; pt_sh out S*Y (share s at [s*N +: N]).
REQ-010 Core-side inputs: core_done in 1; core_ct in Y; core_tag in 128; core_auth_ok in 1.
REQ-011 Output-side ports: out_valid out 1; out_ready in 1; out_ct out W; out_tag out W; out_ct_vld out 1; out_tag_vld out 1; out_last out 1; out_auth_ok out 1.

Function
REQ-012 FSM states LOAD, LOADED, BUSY, UNLOAD; reset state LOAD.
REQ-013 LOAD: in_ready=1; beat = in_valid&in_ready; each beat increments load counter lc.
REQ-014 Each field of length N shifts on a beat only while lc < N/W: reg <= {reg[N-W-1:0], lane}; lane bit W-1 is more significant (MSB-first).
REQ-015 M = max(K,128,L,Y)/W; beat with lc = M-1 moves state to LOADED; in_ready=0 from next cycle.
REQ-016 LOADED: loaded=1; start=1 gives core_start=1 exactly one cycle and state BUSY next cycle.
REQ-017 start outside LOADED is ignored; core_start is never asserted otherwise.
REQ-018 BUSY: core_done=1 captures core_ct, core_tag, core_auth_ok into output registers, clears unload counter uc, goes UNLOAD; core_done in other states ignored.
REQ-019 UNLOAD: out_valid=1; beat uc drives out_ct=ct[uc*W +: W] and out_tag=tag[uc*W +: W] (LSB-first).
REQ-020 out_ct_vld = (uc < Y/W); out_tag_vld = (uc < 128/W); lanes not valid drive 0.
REQ-021 uc advances only on out_valid&out_ready; all out_* held stable while out_ready=0.
REQ-022 out_last=1 on beat uc = max(Y,128)/W - 1; its acceptance clears lc and all field registers and returns to LOAD.
REQ-023 When captured core_auth_ok=0, out_ct and out_tag drive all zeros for the whole unload; out_auth_ok reflects the captured flag.
REQ-024 abort=1 in any state: next cycle state LOAD, lc=uc=0, field and output registers cleared, core_start=0.
REQ-025 rst has priority over abort; abort has priority over start, core_done and beats in the same cycle.
REQ-026 key_sh, nonce_sh, ad_sh, pt_sh are direct register outputs, stable from LOADED until return to LOAD.

Reset
REQ-027 rst: state LOAD, lc=uc=0, all field and capture registers 0.
REQ-028 Reset values: in_ready=1, loaded=0, core_start=0, out_valid=0, out_last=0, out_ct_vld=out_tag_vld=0, out_ct=out_tag=0, out_auth_ok=0.
REQ-029 rst mid-load or mid-unload discards all partial data; no residual beat is counted.

Structure
REQ-030 Package ascon_sio_pkg holds the state enumeration, the W legality check and a max-of-lengths beat-count function.
REQ-031 Sub-module ascon_sio_shreg: parametrised N-bit, W-lane, count-limited left-shift register with enable and clear; one instance per field per share.
REQ-032 Output serialisation is index-based on captured registers; no second shift chain.

Verification
REQ-033 W=1, K=128, L=Y=32, S=5: 128 beats, key lane 0 all 1s -> key_sh[127:0]=all 1s; loaded=1 after beat 128; in_ready=0.
REQ-034 start pulsed at beat 50 -> no core_start; start in LOADED -> one-cycle core_start, state BUSY.
REQ-035 W=8: 16 beats load; core_ct=32'h12345678, auth_ok=1 -> out_ct beats 78,56,34,12, then out_ct_vld=0; out_last on beat 16.
REQ-036 out_ready low 3 cycles at uc=5 -> out_tag/out_ct unchanged 3 cycles, uc resumes at 5.
REQ-037 core_auth_ok=0 -> all out_ct/out_tag beats 0, out_auth_ok=0.
REQ-038 abort asserted at uc=7 -> next cycle LOAD, in_ready=1, out_valid=0, key_sh=0.
